// File: rtl/cache_mem_arbiter.sv
// Round-robin AXI4-Lite arbiter sharing one memory port between the I-cache and D-cache masters.
// Define CACHE_ARB_FIXED_PRIO_EN to make requester 0 win every tie.
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [2*ADDR_W-1:0]     s_awaddr,
  input  logic [2*ADDR_W-1:0]     s_araddr,
  input  logic [1:0]              s_awvalid,
  input  logic [1:0]              s_wvalid,
  input  logic [1:0]              s_arvalid,
  input  logic [2*DATA_W-1:0]     s_wdata,
  input  logic [2*(DATA_W/8)-1:0] s_wstrb,
  output logic [1:0]              s_awready,
  output logic [1:0]              s_wready,
  output logic [1:0]              s_arready,
  output logic [1:0]              s_bvalid,
  output logic [1:0]              s_rvalid,
  input  logic [1:0]              s_bready,
  input  logic [1:0]              s_rready,
  output logic [1:0]              s_bresp,
  output logic [1:0]              s_rresp,
  output logic [DATA_W-1:0]       s_rdata,
  output logic [ADDR_W-1:0]       m_awaddr,
  output logic [ADDR_W-1:0]       m_araddr,
  output logic                    m_awvalid,
  output logic                    m_wvalid,
  output logic                    m_arvalid,
  output logic                    m_bready,
  output logic                    m_rready,
  input  logic                    m_awready,
  input  logic                    m_wready,
  input  logic                    m_arready,
  input  logic                    m_bvalid,
  input  logic                    m_rvalid,
  output logic [DATA_W-1:0]       m_wdata,
  output logic [DATA_W/8-1:0]     m_wstrb,
  input  logic [1:0]              m_bresp,
  input  logic [1:0]              m_rresp,
  input  logic [DATA_W-1:0]       m_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    WRET,
    RADDR,
    RDATA,
    RRET
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                grant;
  logic                last_grant;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          resp_q;
  logic                aw_done;
  logic                w_done;

  logic [1:0]          wr_req;
  logic [1:0]          any_req;
  logic                win;
  logic                win_write;
  logic                accept;
  logic                aw_hs;
  logic                w_hs;
  logic                ret_hs;

  // Arbitration: a lone requester wins outright, a tie goes away from last_grant
  always_comb begin
    wr_req  = s_awvalid & s_wvalid;
    any_req = wr_req | s_arvalid;
    if (any_req == 2'b11) begin
`ifdef CACHE_ARB_FIXED_PRIO_EN
      win = 1'b0;
`else
      win = ~last_grant;
`endif
    end else begin
      win = ~any_req[0];
    end
    win_write = wr_req[win];
    accept    = (state == IDLE) && (any_req != 2'b00);
    aw_hs     = m_awvalid && m_awready;
    w_hs      = m_wvalid && m_wready;
    ret_hs    = ((state == WRET) && s_bready[grant]) ||
                ((state == RRET) && s_rready[grant]);
  end

  always_comb begin
    state_nxt = state;
    s_awready = 2'b00;
    s_wready  = 2'b00;
    s_arready = 2'b00;
    s_bvalid  = 2'b00;
    s_rvalid  = 2'b00;

    s_awready[win] = accept && win_write;
    s_wready[win]  = accept && win_write;
    s_arready[win] = accept && !win_write;
    s_bvalid[grant] = (state == WRET);
    s_rvalid[grant] = (state == RRET);

    m_awvalid = (state == WADDR) && !aw_done;
    m_wvalid  = (state == WADDR) && !w_done;
    m_bready  = (state == WRESP);
    m_arvalid = (state == RADDR);
    m_rready  = (state == RDATA);

    case (state)
      IDLE:    if (accept) state_nxt = win_write ? WADDR : RADDR;
      WADDR:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WRESP;
      WRESP:   if (m_bvalid) state_nxt = WRET;
      WRET:    if (s_bready[grant]) state_nxt = IDLE;
      RADDR:   if (m_arready) state_nxt = RDATA;
      RDATA:   if (m_rvalid) state_nxt = RRET;
      RRET:    if (s_rready[grant]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request registers are loaded only on acceptance so the memory side sees stable values
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      resp_q     <= 2'b00;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        grant   <= win;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        if (win_write) begin
          addr_q  <= win ? s_awaddr[2*ADDR_W-1:ADDR_W] : s_awaddr[ADDR_W-1:0];
          wdata_q <= win ? s_wdata[2*DATA_W-1:DATA_W] : s_wdata[DATA_W-1:0];
          wstrb_q <= win ? s_wstrb[2*STRB_W-1:STRB_W] : s_wstrb[STRB_W-1:0];
        end else begin
          addr_q  <= win ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
        end
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      if ((state == WRESP) && m_bvalid) resp_q <= m_bresp;
      if ((state == RDATA) && m_rvalid) begin
        rdata_q <= m_rdata;
        resp_q  <= m_rresp;
      end
      if (ret_hs) last_grant <= grant;
    end
  end

  assign m_awaddr = addr_q;
  assign m_araddr = addr_q;
  assign m_wdata  = wdata_q;
  assign m_wstrb  = wstrb_q;
  assign s_rdata  = rdata_q;
  assign s_bresp  = resp_q;
  assign s_rresp  = resp_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized bench for cache_mem_arbiter: two requester models, a memory slave model and
// a transaction-level reference that predicts grants, routing, data and latency.
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            CLK;
  logic            RST;
  logic [2*AW-1:0] s_awaddr, s_araddr;
  logic [1:0]      s_awvalid, s_wvalid, s_arvalid;
  logic [2*DW-1:0] s_wdata;
  logic [2*SW-1:0] s_wstrb;
  logic [1:0]      s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic [1:0]      s_bready, s_rready, s_bresp, s_rresp;
  logic [DW-1:0]   s_rdata;
  logic [AW-1:0]   m_awaddr, m_araddr;
  logic            m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
  logic            m_awready, m_wready, m_arready, m_bvalid, m_rvalid;
  logic [DW-1:0]   m_wdata;
  logic [SW-1:0]   m_wstrb;
  logic [1:0]      m_bresp, m_rresp;
  logic [DW-1:0]   m_rdata;

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .RST(RST),
    .s_awaddr(s_awaddr), .s_araddr(s_araddr),
    .s_awvalid(s_awvalid), .s_wvalid(s_wvalid), .s_arvalid(s_arvalid),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_awready(s_awready), .s_wready(s_wready), .s_arready(s_arready),
    .s_bvalid(s_bvalid), .s_rvalid(s_rvalid),
    .s_bready(s_bready), .s_rready(s_rready),
    .s_bresp(s_bresp), .s_rresp(s_rresp), .s_rdata(s_rdata),
    .m_awaddr(m_awaddr), .m_araddr(m_araddr),
    .m_awvalid(m_awvalid), .m_wvalid(m_wvalid), .m_arvalid(m_arvalid),
    .m_bready(m_bready), .m_rready(m_rready),
    .m_awready(m_awready), .m_wready(m_wready), .m_arready(m_arready),
    .m_bvalid(m_bvalid), .m_rvalid(m_rvalid),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bresp(m_bresp), .m_rresp(m_rresp), .m_rdata(m_rdata)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int compare_count;
  int mismatch_count;

  // Requester models: an AW+W channel and an AR channel each, plus outstanding flags
  bit          w_active [2];
  logic [31:0] w_addr   [2];
  logic [31:0] w_data   [2];
  logic [3:0]  w_strb   [2];
  bit          r_active [2];
  logic [31:0] r_addr   [2];
  bit          wait_b   [2];
  bit          wait_r   [2];

  // Memory slave model
  bit          sl_aw_got, sl_w_got, sl_b_pend, sl_r_pend;
  logic [31:0] sl_aw_addr, sl_w_data, sl_r_data;
  logic [3:0]  sl_w_strb;
  logic [1:0]  sl_b_resp, sl_r_resp;
  logic [31:0] slave_mem [logic [31:0]];

  // Transaction-level reference
  bit          model_idle;
  bit          ref_last;
  bit          cur_grant;
  bit          cur_write;
  logic [31:0] cur_addr, cur_data, exp_rdata;
  logic [3:0]  cur_strb;
  logic [1:0]  exp_resp;
  int          lat;
  bit          resp_seen;
  bit          aw_seen, w_seen, ar_seen;
  bit          aw_hold_prev, w_hold_prev, ar_hold_prev;
  logic [31:0] ref_mem [logic [31:0]];

  bit zero_wait, hold_r, gen_enable;

  logic [31:0] addr_pool [8] = '{32'h11111111, 32'h10111112, 32'h11011112, 32'h40400000,
                                 32'h40500000, 32'h20000004, 32'h30000008, 32'h4000000C};

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [1:0] resp_for(input logic [31:0] a);
    return a[3:2];
  endfunction

  function automatic logic [31:0] merge_strb(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] read_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : default_word(a);
  endfunction

  function automatic logic [31:0] read_slave(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : default_word(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compare_count++;
    if (actual !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  endtask

  task automatic reset_models();
    for (int i = 0; i < 2; i++) begin
      w_active[i] = 0; r_active[i] = 0; wait_b[i] = 0; wait_r[i] = 0;
      w_addr[i] = '0; w_data[i] = '0; w_strb[i] = '0; r_addr[i] = '0;
    end
    sl_aw_got = 0; sl_w_got = 0; sl_b_pend = 0; sl_r_pend = 0;
    sl_aw_addr = '0; sl_w_data = '0; sl_w_strb = '0; sl_r_data = '0;
    sl_b_resp = 2'b00; sl_r_resp = 2'b00;
    slave_mem.delete();
    ref_mem.delete();
    model_idle = 1; ref_last = 1; lat = 0; resp_seen = 0;
    aw_seen = 0; w_seen = 0; ar_seen = 0;
    aw_hold_prev = 0; w_hold_prev = 0; ar_hold_prev = 0;
    hold_r = 0;
    m_bvalid = 1'b0;
    m_rvalid = 1'b0;
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 2; i++) begin
      if (gen_enable) begin
        if (!w_active[i] && !wait_b[i] && $urandom_range(0, 3) == 0) begin
          w_active[i] = 1;
          w_addr[i]   = addr_pool[$urandom_range(0, 7)];
          w_data[i]   = $urandom;
          w_strb[i]   = 4'($urandom_range(1, 15));
        end
        if (!r_active[i] && !wait_r[i] && $urandom_range(0, 3) == 0) begin
          r_active[i] = 1;
          r_addr[i]   = addr_pool[$urandom_range(0, 7)];
        end
      end
    end
    s_awvalid = {w_active[1], w_active[0]};
    s_wvalid  = {w_active[1], w_active[0]};
    s_arvalid = {r_active[1], r_active[0]};
    s_awaddr  = {w_addr[1], w_addr[0]};
    s_wdata   = {w_data[1], w_data[0]};
    s_wstrb   = {w_strb[1], w_strb[0]};
    s_araddr  = {r_addr[1], r_addr[0]};
    s_bready  = zero_wait ? 2'b11 : 2'($urandom_range(0, 3));
    s_rready  = zero_wait ? 2'b11 : 2'($urandom_range(0, 3));
    m_awready = !sl_aw_got && !sl_b_pend && (zero_wait || $urandom_range(0, 2) == 0);
    m_wready  = !sl_w_got && !sl_b_pend && (zero_wait || $urandom_range(0, 2) == 0);
    m_bvalid  = sl_b_pend && (m_bvalid || zero_wait || $urandom_range(0, 2) == 0);
    m_bresp   = sl_b_resp;
    m_arready = !sl_r_pend && (zero_wait || $urandom_range(0, 2) == 0);
    m_rvalid  = sl_r_pend && !hold_r && (m_rvalid || zero_wait || $urandom_range(0, 2) == 0);
    m_rdata   = sl_r_data;
    m_rresp   = sl_r_resp;
  endtask

  task automatic sample_cycle();
    logic [1:0] wq, rq, anyq, exp_aw, exp_ar, exp_b, exp_r;
    bit         w, is_w;

    if (!model_idle) begin
      lat++;
      if (lat > 400) begin
        checkOutput("txn_timeout", 64'(lat), 64'd400);
        finish_run();
      end
      checkOutput("ready_busy", {s_awready, s_wready, s_arready}, 6'b0);
      if (m_awvalid) begin
        checkOutput("m_awvalid_legal", {cur_write, aw_seen}, 2'b10);
        checkOutput("m_awaddr", m_awaddr, cur_addr);
      end
      if (m_wvalid) begin
        checkOutput("m_wvalid_legal", {cur_write, w_seen}, 2'b10);
        checkOutput("m_wdata", {m_wstrb, m_wdata}, {cur_strb, cur_data});
      end
      if (m_arvalid) begin
        checkOutput("m_arvalid_legal", {cur_write, ar_seen}, 2'b00);
        checkOutput("m_araddr", m_araddr, cur_addr);
      end
      if (aw_hold_prev) checkOutput("m_awvalid_hold", m_awvalid, 1'b1);
      if (w_hold_prev) checkOutput("m_wvalid_hold", m_wvalid, 1'b1);
      if (ar_hold_prev) checkOutput("m_arvalid_hold", m_arvalid, 1'b1);
      if (m_awvalid && m_awready) aw_seen = 1;
      if (m_wvalid && m_wready) w_seen = 1;
      if (m_arvalid && m_arready) ar_seen = 1;
      aw_hold_prev = m_awvalid && !m_awready;
      w_hold_prev  = m_wvalid && !m_wready;
      ar_hold_prev = m_arvalid && !m_arready;

      if (s_bvalid != 2'b00 || s_rvalid != 2'b00) begin
        exp_b = cur_write ? (2'b01 << cur_grant) : 2'b00;
        exp_r = cur_write ? 2'b00 : (2'b01 << cur_grant);
        checkOutput("resp_route", {s_bvalid, s_rvalid}, {exp_b, exp_r});
        if (!resp_seen && zero_wait) checkOutput("latency", 64'(lat), 64'd3);
        resp_seen = 1;
        if (cur_write) begin
          checkOutput("s_bresp", s_bresp, exp_resp);
          if (s_bvalid[cur_grant] && s_bready[cur_grant]) begin
            model_idle = 1; ref_last = cur_grant; wait_b[cur_grant] = 0;
          end
        end else begin
          checkOutput("s_rdata", {s_rresp, s_rdata}, {exp_resp, exp_rdata});
          if (s_rvalid[cur_grant] && s_rready[cur_grant]) begin
            model_idle = 1; ref_last = cur_grant; wait_r[cur_grant] = 0;
          end
        end
      end
    end else begin
      checkOutput("idle_quiet", {s_bvalid, s_rvalid, m_awvalid, m_wvalid, m_arvalid}, 7'b0);
      wq   = {w_active[1], w_active[0]};
      rq   = {r_active[1], r_active[0]};
      anyq = wq | rq;
      exp_aw = 2'b00;
      exp_ar = 2'b00;
      w = 0;
      is_w = 0;
      if (anyq != 2'b00) begin
`ifdef CACHE_ARB_FIXED_PRIO_EN
        w = (anyq == 2'b11) ? 1'b0 : !anyq[0];
`else
        w = (anyq == 2'b11) ? !ref_last : !anyq[0];
`endif
        is_w = wq[w];
        if (is_w) exp_aw[w] = 1'b1;
        else exp_ar[w] = 1'b1;
      end
      checkOutput("s_awready", s_awready, exp_aw);
      checkOutput("s_wready", s_wready, exp_aw);
      checkOutput("s_arready", s_arready, exp_ar);
      if (anyq != 2'b00) begin
        model_idle = 0; cur_grant = w; cur_write = is_w;
        lat = 0; resp_seen = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0;
        aw_hold_prev = 0; w_hold_prev = 0; ar_hold_prev = 0;
        if (is_w) begin
          cur_addr = w_addr[w]; cur_data = w_data[w]; cur_strb = w_strb[w];
          ref_mem[cur_addr] = merge_strb(read_ref(cur_addr), cur_data, cur_strb);
          w_active[w] = 0; wait_b[w] = 1;
        end else begin
          cur_addr = r_addr[w]; cur_data = '0; cur_strb = '0;
          exp_rdata = read_ref(cur_addr);
          r_active[w] = 0; wait_r[w] = 1;
        end
        exp_resp = resp_for(cur_addr);
      end
    end

    // Memory slave bookkeeping, driven purely by what appears on the memory port
    if (m_bvalid && m_bready) sl_b_pend = 0;
    if (m_awvalid && m_awready) begin sl_aw_got = 1; sl_aw_addr = m_awaddr; end
    if (m_wvalid && m_wready) begin sl_w_got = 1; sl_w_data = m_wdata; sl_w_strb = m_wstrb; end
    if (sl_aw_got && sl_w_got) begin
      slave_mem[sl_aw_addr] = merge_strb(read_slave(sl_aw_addr), sl_w_data, sl_w_strb);
      sl_b_pend = 1; sl_b_resp = resp_for(sl_aw_addr);
      sl_aw_got = 0; sl_w_got = 0;
    end
    if (m_rvalid && m_rready) sl_r_pend = 0;
    if (m_arvalid && m_arready) begin
      sl_r_pend = 1; sl_r_data = read_slave(m_araddr); sl_r_resp = resp_for(m_araddr);
    end
  endtask

  task automatic step_cycle();
    @(negedge CLK);
    sample_cycle();
    @(posedge CLK);
    #1;
    applyStimulus();
  endtask

  task automatic run_until_idle(input int max_cycles);
    int n;
    n = 0;
    while (!(model_idle && !w_active[0] && !w_active[1] && !r_active[0] && !r_active[1] &&
             !wait_b[0] && !wait_b[1] && !wait_r[0] && !wait_r[1]) && n < max_cycles) begin
      step_cycle();
      n++;
    end
    if (n >= max_cycles) checkOutput("drain_timeout", 64'(n), 64'(max_cycles - 1));
  endtask

  task automatic check_reset_state(input string ph);
    checkOutput({ph, "_handshakes"}, {s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
                m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 15'b0);
    checkOutput({ph, "_m_addr"}, {m_awaddr, m_araddr}, 64'h0);
    checkOutput({ph, "_m_wdata"}, {m_wstrb, m_wdata}, 36'h0);
    checkOutput({ph, "_s_rdata"}, {s_bresp, s_rresp, s_rdata}, 36'h0);
  endtask

  initial begin
    int n;
    compare_count  = 0;
    mismatch_count = 0;
    zero_wait  = 1;
    gen_enable = 0;
    reset_models();
    applyStimulus();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check_reset_state("por");
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Contention on reads straight after reset: requester 0 first
    r_active[0] = 1; r_addr[0] = 32'h10111112;
    r_active[1] = 1; r_addr[1] = 32'h11011112;
    applyStimulus();
    run_until_idle(100);

    // Requester 1 offers a write and a read together; the write must go first
    w_active[1] = 1; w_addr[1] = 32'h40400000; w_data[1] = 32'h12345678; w_strb[1] = 4'hF;
    r_active[1] = 1; r_addr[1] = 32'h40500000;
    applyStimulus();
    run_until_idle(100);

    // Single full-word write from requester 0, then read it back
    w_active[0] = 1; w_addr[0] = 32'h11111111; w_data[0] = 32'hCCCCCCCC; w_strb[0] = 4'hF;
    applyStimulus();
    run_until_idle(100);
    r_active[0] = 1; r_addr[0] = 32'h11111111;
    applyStimulus();
    run_until_idle(100);

    gen_enable = 1;
    repeat (300) step_cycle();
    gen_enable = 0;
    run_until_idle(200);

    zero_wait  = 0;
    gen_enable = 1;
    repeat (2500) step_cycle();
    gen_enable = 0;
    run_until_idle(2000);

    // Reset while the read sits waiting for memory data
    zero_wait = 1;
    hold_r    = 1;
    r_active[0] = 1; r_addr[0] = 32'h20000004;
    applyStimulus();
    n = 0;
    while (!m_rready && n < 50) begin
      step_cycle();
      n++;
    end
    checkOutput("reach_rdata", m_rready, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    check_reset_state("mid");
    reset_models();
    applyStimulus();
    @(posedge CLK);
    #1;
    RST = 1'b0;

    r_active[0] = 1; r_addr[0] = 32'h30000008;
    r_active[1] = 1; r_addr[1] = 32'h4000000C;
    applyStimulus();
    run_until_idle(100);

    finish_run();
  end

endmodule
